// File: rtl/piso_serializer_if.sv
// Load handshake and serial-output bundle of piso_serializer.
// master: word source / link monitor (drives load_valid, load_data).
// slave : the serializer (drives load_ready, serial_out, serial_valid, busy, done).
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, serial_out, serial_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, serial_out, serial_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: one WIDTH-bit word per frame, one bit per clk.
// Latency: first bit on serial_out the cycle after accept; frames can run gapless.
// Backpressure: load_ready low mid-frame; a held load_valid is taken in the frame's last cycle.
// Ports: clk, rst (sync, active-high); link (slave modport of piso_serializer_if).
// Optional macro PISO_PARITY_EN appends one even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  piso_serializer_if.slave link
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             serial_out_q;
  logic             serial_valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  logic             last_bit;
  logic             accept;
  logic [CW-1:0]    cnt_d;
  logic             load_bit_d;
  logic [WIDTH-1:0] load_rest_d;
  logic             shift_bit_d;
  logic [WIDTH-1:0] shift_rest_d;

  // cnt_q is the index of the bit currently on serial_out.
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);

`ifdef PISO_PARITY_EN
  // The parity cycle is the frame's final cycle, so the early-accept window moves there.
  assign link.load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
  assign link.load_ready = (state_q == IDLE) || last_bit;
`endif

  assign accept = link.load_valid && link.load_ready;
  assign cnt_d  = cnt_q + CW'(1);

  // Head bit of a word and the word with that bit consumed; the shift
  // register always holds only the bits still to be sent.
  assign load_bit_d   = LSB_FIRST ? link.load_data[0] : link.load_data[WIDTH-1];
  assign load_rest_d  = LSB_FIRST ? {1'b0, link.load_data[WIDTH-1:1]}
                                  : {link.load_data[WIDTH-2:0], 1'b0};
  assign shift_bit_d  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign shift_rest_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                  : {shreg_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else if (accept) begin
      // Covers both a load from IDLE and a gapless reload in the last cycle.
      state_q        <= SHIFT;
      shreg_q        <= load_rest_d;
      cnt_q          <= '0;
      serial_out_q   <= load_bit_d;
      serial_valid_q <= 1'b1;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q       <= ^link.load_data;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (!last_bit) begin
            shreg_q      <= shift_rest_d;
            cnt_q        <= cnt_d;
            serial_out_q <= shift_bit_d;
`ifdef PISO_PARITY_EN
            done_q       <= 1'b0;
`else
            done_q       <= (cnt_d == LAST_IDX);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_q      <= PARITY;
            serial_out_q <= parity_q;
            done_q       <= 1'b1;
`else
            state_q        <= IDLE;
            shreg_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`endif
          end
        end
        default: begin
          // IDLE, or the parity cycle ending with no new word.
          state_q        <= IDLE;
          shreg_q        <= '0;
          cnt_q          <= '0;
          serial_out_q   <= 1'b0;
          serial_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          done_q         <= 1'b0;
        end
      endcase
    end
  end

  assign link.serial_out   = serial_out_q;
  assign link.serial_valid = serial_valid_q;
  assign link.busy         = busy_q;
  assign link.done         = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first and an MSB-first instance share one
// stimulus stream; a frame-queue model is compared every cycle and directed
// sequences pin hand-computed bit streams, a loopback receiver and reset abort.
module tb_piso_serializer;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         lv;
  logic [W-1:0] ld;
  logic [W-1:0] rx;
  int           errors;
  int           checks;
  bit           mdl_on;

  // Per-instance queue of frame bits still to appear on serial_out (front = now).
  logic ql[$];
  logic qm[$];

  piso_serializer_if #(.WIDTH(W)) ifl ();
  piso_serializer_if #(.WIDTH(W)) ifm ();

  assign ifl.load_valid = lv;
  assign ifl.load_data  = ld;
  assign ifm.load_valid = lv;
  assign ifm.load_data  = ld;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .link(ifl));
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .link(ifm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit shift-in receiver, entering at its MSB end.
  always @(posedge clk) begin
    if (rst) rx <= '0;
    else if (ifl.serial_valid) rx <= {ifl.serial_out, rx[W-1:1]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is accepted when the pending queue has at most one bit left.
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      ql.delete();
      qm.delete();
      mdl_on = 1'b1;
    end else if (mdl_on) begin
      acc = lv && (ql.size() <= 1);
      if (ql.size() > 0) ql.delete(0);
      if (qm.size() > 0) qm.delete(0);
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          ql.push_back(ld[i]);
          qm.push_back(ld[W-1-i]);
        end
`ifdef PISO_PARITY_EN
        ql.push_back(^ld);
        qm.push_back(^ld);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("l_serial_out",   ifl.serial_out,   (ql.size() > 0) ? ql[0] : 1'b0);
      chk("l_serial_valid", ifl.serial_valid, ql.size() > 0);
      chk("l_busy",         ifl.busy,         ql.size() > 0);
      chk("l_done",         ifl.done,         ql.size() == 1);
      chk("l_load_ready",   ifl.load_ready,   ql.size() <= 1);
      chk("m_serial_out",   ifm.serial_out,   (qm.size() > 0) ? qm[0] : 1'b0);
      chk("m_serial_valid", ifm.serial_valid, qm.size() > 0);
      chk("m_done",         ifm.done,         qm.size() == 1);
      chk("m_load_ready",   ifm.load_ready,   qm.size() <= 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_so"},    ifl.serial_out, 1'b0);
    chk({nm, "_vld"},   ifl.serial_valid, 1'b0);
    chk({nm, "_busy"},  ifl.busy, 1'b0);
    chk({nm, "_ready"}, ifl.load_ready, 1'b1);
  endtask

`ifdef PISO_PARITY_EN
  logic t6a [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic t6b [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
  logic t1l [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic t1m [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic t2  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic t3  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic t5m [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
`endif

  initial begin
    errors = 0;
    checks = 0;
    mdl_on = 1'b0;
    rst = 1'b1;
    lv  = 1'b0;
    ld  = '0;
    repeat (3) tick();
    chk("reset_so",   ifl.serial_out, 1'b0);
    chk("reset_vld",  ifl.serial_valid, 1'b0);
    chk("reset_done", ifl.done, 1'b0);
    rst = 1'b0;
    chk_idle("post_reset");
    tick();

`ifdef PISO_PARITY_EN
    lv = 1'b1; ld = 4'b0111; tick(); lv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t6a_so",   ifl.serial_out, t6a[i]);
      chk("t6a_vld",  ifl.serial_valid, 1'b1);
      chk("t6a_done", ifl.done, i == 4);
      tick();
    end
    chk_idle("t6a_end");
    tick();
    lv = 1'b1; ld = 4'b0101; tick(); lv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t6b_so",   ifl.serial_out, t6b[i]);
      chk("t6b_done", ifl.done, i == 4);
      tick();
    end
    chk_idle("t6b_end");
`else
    // Single frame, both bit orders, plus loopback of 1101.
    lv = 1'b1; ld = 4'b1101; tick(); lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_so_lsb", ifl.serial_out, t1l[i]);
      chk("t1_so_msb", ifm.serial_out, t1m[i]);
      chk("t1_vld",    ifl.serial_valid, 1'b1);
      chk("t1_busy",   ifl.busy, 1'b1);
      chk("t1_done",   ifl.done, i == 3);
      tick();
    end
    chk_idle("t1_end");
    chk("t1_loopback", rx, 4'b1101);
    tick();

    // Back-to-back frames with load_valid held.
    lv = 1'b1; ld = 4'b0011; tick(); ld = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) lv = 1'b0;
      chk("t2_so",   ifl.serial_out, t2[i]);
      chk("t2_vld",  ifl.serial_valid, 1'b1);
      chk("t2_done", ifl.done, (i == 3) || (i == 7));
      if (i == 1) chk("t2_ready_mid", ifl.load_ready, 1'b0);
      if (i == 3) chk("t2_ready_last", ifl.load_ready, 1'b1);
      tick();
    end
    chk_idle("t2_end");
    tick();

    // Backpressure: 1111 offered during cycle 2 of a 0000 frame.
    lv = 1'b1; ld = 4'b0000; tick(); lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin lv = 1'b1; ld = 4'b1111; end
      if (i == 4) lv = 1'b0;
      chk("t3_so",  ifl.serial_out, t3[i]);
      chk("t3_vld", ifl.serial_valid, 1'b1);
      if (i == 1 || i == 2) chk("t3_ready_low", ifl.load_ready, 1'b0);
      tick();
    end
    chk_idle("t3_end");
    tick();

    // Reset in cycle 2 of a 1011 frame.
    lv = 1'b1; ld = 4'b1011; tick(); lv = 1'b0;
    chk("t4_so_c1", ifl.serial_out, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("t4_so",   ifl.serial_out, 1'b0);
    chk("t4_vld",  ifl.serial_valid, 1'b0);
    chk("t4_busy", ifl.busy, 1'b0);
    chk("t4_done", ifl.done, 1'b0);
    rst = 1'b0;
    tick();
    chk_idle("t4_after");
    tick();

    // Loopback of 1001 and MSB-first order.
    lv = 1'b1; ld = 4'b1001; tick(); lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_so_msb", ifm.serial_out, t5m[i]);
      tick();
    end
    chk("t5_loopback", rx, 4'b1001);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shifter: the transmit end of the serial link whose receive end is the team's 4-bit shift-in register.
- Accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per clk with a qualifying valid strobe.
- Default bit order is LSB-first, so a receiver that shifts in at its MSB end reconstructs the word unchanged after WIDTH bits.
- Supports gapless back-to-back frames.

Parameters:
WIDTH, 4, data word width in bits; legal range 2..32.
LSB_FIRST, 1, 1 = transmit bit 0 first; 0 = transmit bit WIDTH-1 first.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, synchronous, active-high.
load_valid  input  1  sender has a word on load_data.
load_ready  output  1  serializer can accept a word this cycle.
load_data  input  WIDTH  word to transmit; sampled only on handshake.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out carries a frame bit this cycle.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse, high while the final bit of a frame is on serial_out.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk. It has priority over everything, including an in-flight frame, which is aborted with no done pulse. State returns to IDLE; shift register and bit counter clear.
- Register reset values: serial_out=0, serial_valid=0, busy=0, done=0. Combinational load_ready=1 in the first cycle after reset.
- Registers: shift register of WIDTH bits; bit counter of $clog2(WIDTH+1) bits; state.
- States: IDLE and SHIFT, plus PARITY when the optional feature is compiled in.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready. The sender holds load_data stable until accepted. load_valid while load_ready=0 is ignored; no loss or corruption.
- load_ready (combinational) = (state==IDLE) || (state==SHIFT && last bit on serial_out && no PARITY state follows).
- IDLE -> SHIFT on accept. On the edge after accept, serial_out = first bit (load_data[0] if LSB_FIRST, else load_data[WIDTH-1]); serial_valid=1; busy=1. Latency from accept edge to first bit: 1 cycle.
- SHIFT: each edge presents the next bit and increments the counter. The frame occupies exactly WIDTH consecutive cycles.
- done=1 during the WIDTH-th bit cycle.
- Last bit with a new accept in the same cycle: SHIFT -> SHIFT. The new word's first bit follows with zero idle cycles, and the counter reloads.
- Last bit with no accept: SHIFT -> IDLE. Next cycle serial_out=0, serial_valid=0, busy=0.
- Outside a frame: serial_out is driven 0, never X.
- No wrap-around: the counter saturates at its reload point and never exceeds WIDTH-1 in SHIFT.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, the PARITY state emits one even-parity bit (XOR of the word) with serial_valid=1.
  - The frame is WIDTH+1 cycles; done moves to the parity cycle.
  - load_ready's early-accept term applies in the PARITY cycle instead of the last data cycle.
- Undefined: the PARITY state, parity logic and its load_ready term are absent; the frame is WIDTH cycles as above.

Test Plan:
1. WIDTH=4, LSB_FIRST=1: accept 4'b1101 at edge 0 -> serial_out 1,0,1,1 on cycles 1-4; serial_valid=1 and busy=1 on cycles 1-4; done only on cycle 4; cycle 5 serial_out=0, serial_valid=0, load_ready=1.
2. Back-to-back: 4'b0011, then 4'b1010 with load_valid held -> second accept coincides with cycle 4. Stream 1,1,0,0,0,1,0,1 over cycles 1-8 with serial_valid continuously 1; done on cycles 4 and 8.
3. Backpressure: assert load_valid with 4'b1111 during cycle 2 of a 4'b0000 frame -> load_ray deasserted; no corruption of the current frame (0,0,0,0); 1111 is accepted on cycle 4 and sent on cycles 5-8.
4. Reset mid-frame: rst=1 on cycle 2 of 4'b1011 -> next cycle serial_out=0, serial_valid=0, busy=0, no done pulse; load_ready=1 after rst drops.
5. Loopback into the 4-bit shift-in receiver: send 4'b1001 LSB-first -> receiver parallel_out = 4'b1001 on the edge after the 4th bit; LSB_FIRST=0 sends 1,0,0,1 MSB-first.
6. PISO_PARITY_EN defined: 4'b0111 -> serial_out 1,1,1,0,1 over cycles 1-5; done on cycle 5. 4'b0101 -> parity bit 0.
